// File: rtl/nlp_vec_mem_pkg.sv
// Shared types for the NLP vector memory: read modes, FSM states and the
// byte-merge helper used by the write port and the optional bypass path.
package nlp_mem_pkg;

  typedef enum logic [1:0] {
    RD_PAIR   = 2'b00,
    RD_SINGLE = 2'b01,
    RD_BURST  = 2'b10,
    RD_RSVD   = 2'b11
  } rd_mode_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

  // Widest word merge_be handles; callers zero-extend and truncate around it.
  localparam int MERGE_W = 512;

  function automatic logic [MERGE_W-1:0] merge_be(
    input logic [MERGE_W-1:0]   old_w,
    input logic [MERGE_W-1:0]   new_w,
    input logic [MERGE_W/8-1:0] be
  );
    logic [MERGE_W-1:0] res;
    res = old_w;
    for (int i = 0; i < MERGE_W/8; i++) begin
      if (be[i]) res[i*8 +: 8] = new_w[i*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/nlp_vec_mem_if.sv
// Read request/response and write port bundle of the NLP vector memory.
// master = producer of requests (DMA / compute unit side), slave = memory.
interface nlp_vec_mem_if import nlp_mem_pkg::*; #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 32,
  parameter int LEN_W  = 8
) ();
  localparam int ADDR_W = $clog2(DEPTH);

  logic              rd_req;
  logic              rd_req_rdy;
  rd_mode_e          rd_mode;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] rd_stride;
  logic [LEN_W-1:0]  rd_len;
  logic [DATA_W-1:0] rd_data1;
  logic [DATA_W-1:0] rd_data2;
  logic              rd_valid;
  logic              rd_ready;
  logic              rd_last;
  logic              busy;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W/8-1:0] wr_be;

  modport master (
    output rd_req, rd_mode, rd_addr, rd_stride, rd_len, rd_ready,
    output wr_en, wr_addr, wr_data, wr_be,
    input  rd_req_rdy, rd_data1, rd_data2, rd_valid, rd_last, busy
  );

  modport slave (
    input  rd_req, rd_mode, rd_addr, rd_stride, rd_len, rd_ready,
    input  wr_en, wr_addr, wr_data, wr_be,
    output rd_req_rdy, rd_data1, rd_data2, rd_valid, rd_last, busy
  );

endinterface

// File: rtl/nlp_vec_mem_array.sv
// DEPTH x DATA_W storage: one byte-enabled write port, two combinational reads
// at addr and addr+1. NLP_MEM_BYPASS_EN forwards same-cycle writes to the reads.
module nlp_mem_array import nlp_mem_pkg::*; #(
  parameter  int DATA_W = 64,
  parameter  int DEPTH  = 32,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int BE_W   = DATA_W/8
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [BE_W-1:0]   wr_be,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] rd_addr1;
  logic [DATA_W-1:0] wr_merged;

  assign rd_addr1  = rd_addr + ADDR_W'(1);
  assign wr_merged = DATA_W'(merge_be(MERGE_W'(mem[wr_addr]), MERGE_W'(wr_data),
                                      (MERGE_W/8)'(wr_be)));

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_merged;
  end

`ifdef NLP_MEM_BYPASS_EN
  // wr_merged is built over mem[wr_addr], which is the word being read on a hit
  assign rd_data1 = (wr_en && (wr_addr == rd_addr))  ? wr_merged : mem[rd_addr];
  assign rd_data2 = (wr_en && (wr_addr == rd_addr1)) ? wr_merged : mem[rd_addr1];
`else
  assign rd_data1 = mem[rd_addr];
  assign rd_data2 = mem[rd_addr1];
`endif

endmodule

// File: rtl/nlp_vec_mem.sv
// Dual-output vector memory for NLP operand fetch: PAIR/SINGLE/BURST reads with
// ready/valid output register. Optional same-cycle write bypass: NLP_MEM_BYPASS_EN.
//
//  state    | meaning
//  ST_IDLE  | accepts requests; PAIR/SINGLE beats issued directly from here
//  ST_BURST | walking a strided burst, one beat per free output slot
module nlp_vec_mem import nlp_mem_pkg::*; #(
  parameter  int DATA_W = 64,
  parameter  int DEPTH  = 32,
  parameter  int LEN_W  = 8,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input logic          clk,
  input logic          rst,
  nlp_vec_mem_if.slave bus
);

  state_e            state, state_nx;
  logic [ADDR_W-1:0] b_addr, b_addr_nx;
  logic [ADDR_W-1:0] b_stride, b_stride_nx;
  logic [LEN_W-1:0]  b_rem, b_rem_nx;

  logic              issue, issue_single, issue_last;
  logic [ADDR_W-1:0] arr_addr;
  logic [DATA_W-1:0] arr_data1, arr_data2;
  logic              slot_free;

  logic [DATA_W-1:0] data1_q, data2_q;
  logic              valid_q, last_q;

  nlp_mem_array #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_array (
    .clk      (clk),
    .wr_en    (bus.wr_en),
    .wr_addr  (bus.wr_addr),
    .wr_data  (bus.wr_data),
    .wr_be    (bus.wr_be),
    .rd_addr  (arr_addr),
    .rd_data1 (arr_data1),
    .rd_data2 (arr_data2)
  );

  assign slot_free = !valid_q || bus.rd_ready;

  always_comb begin
    state_nx     = state;
    b_addr_nx    = b_addr;
    b_stride_nx  = b_stride;
    b_rem_nx     = b_rem;
    issue        = 1'b0;
    issue_single = 1'b0;
    issue_last   = 1'b0;
    arr_addr     = bus.rd_addr;
    case (state)
      ST_IDLE: begin
        if (bus.rd_req && slot_free) begin
          case (bus.rd_mode)
            RD_PAIR: begin
              issue      = 1'b1;
              issue_last = 1'b1;
            end
            RD_SINGLE: begin
              issue        = 1'b1;
              issue_single = 1'b1;
              issue_last   = 1'b1;
            end
            RD_BURST: begin
              if (bus.rd_len != '0) begin
                state_nx    = ST_BURST;
                b_addr_nx   = bus.rd_addr;
                b_stride_nx = bus.rd_stride;
                b_rem_nx    = bus.rd_len;
              end
            end
            default: ;
          endcase
        end
      end
      ST_BURST: begin
        arr_addr = b_addr;
        if (slot_free) begin
          issue      = 1'b1;
          issue_last = (b_rem == LEN_W'(1));
          b_addr_nx  = b_addr + b_stride;
          b_rem_nx   = b_rem - LEN_W'(1);
          if (issue_last) state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      b_addr   <= '0;
      b_stride <= '0;
      b_rem    <= '0;
    end else begin
      state    <= state_nx;
      b_addr   <= b_addr_nx;
      b_stride <= b_stride_nx;
      b_rem    <= b_rem_nx;
    end
  end

  // Output slot: loads on issue, otherwise held until the consumer takes it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data1_q <= '0;
      data2_q <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else if (issue) begin
      data1_q <= arr_data1;
      data2_q <= issue_single ? '0 : arr_data2;
      valid_q <= 1'b1;
      last_q  <= issue_last;
    end else if (bus.rd_ready) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end
  end

  assign bus.rd_data1   = data1_q;
  assign bus.rd_data2   = data2_q;
  assign bus.rd_valid   = valid_q;
  assign bus.rd_last    = last_q;
  assign bus.busy       = (state != ST_IDLE);
  assign bus.rd_req_rdy = (state == ST_IDLE) && slot_free;

endmodule

// File: tb/tb_nlp_vec_mem.sv
// Self-checking bench for nlp_vec_mem: directed scenarios plus randomized
// requests checked against a word-array reference model.
module tb_nlp_vec_mem;
  import nlp_mem_pkg::*;

  localparam int DATA_W = 64;
  localparam int DEPTH  = 32;
  localparam int LEN_W  = 8;

  typedef struct packed {
    logic [63:0] d1;
    logic [63:0] d2;
    logic        last;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  logic [63:0] model [DEPTH];
  beat_t       exp_q [$];

  nlp_vec_mem_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .LEN_W(LEN_W)) bus ();

  nlp_vec_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [63:0] d, input logic [7:0] be);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    bus.wr_be   = be;
    tick();
    bus.wr_en = 1'b0;
    bus.wr_be = '0;
    for (int i = 0; i < 8; i++) if (be[i]) model[a][i*8 +: 8] = d[i*8 +: 8];
  endtask

  // Expected beats straight from the read rules: word[a], word[a+1 mod DEPTH].
  task automatic expect_beats(input rd_mode_e m, input logic [4:0] a, input logic [4:0] s,
                              input int len);
    int    n;
    int    ak;
    beat_t b;
    exp_q.delete();
    n = (m == RD_BURST) ? len : ((m == RD_RSVD) ? 0 : 1);
    for (int k = 0; k < n; k++) begin
      ak     = (int'(a) + k * int'(s)) % DEPTH;
      b.d1   = model[ak];
      b.d2   = (m == RD_SINGLE) ? 64'h0 : model[(ak + 1) % DEPTH];
      b.last = (k == n - 1);
      exp_q.push_back(b);
    end
  endtask

  // rmode: 0 = always ready, 1 = random ready, 2 = ready low 3 cycles on beat 2
  task automatic run_req(input rd_mode_e m, input logic [4:0] a, input logic [4:0] s,
                         input int len, input int rmode);
    int   n, popped, it, hold, exp_it;
    logic r;
    popped = 0;
    it     = 0;
    hold   = 0;
    expect_beats(m, a, s, len);
    n = exp_q.size();
    bus.rd_req    = 1'b1;
    bus.rd_mode   = m;
    bus.rd_addr   = a;
    bus.rd_stride = s;
    bus.rd_len    = LEN_W'(len);
    bus.rd_ready  = 1'b1;
    #1;
    chk("req_rdy_idle", bus.rd_req_rdy, 1'b1);
    tick();
    bus.rd_req = 1'b0;
    while (exp_q.size() > 0 && it < 200) begin
      if (rmode == 0)      r = 1'b1;
      else if (rmode == 1) r = 1'($urandom_range(0, 1));
      else if (popped == 1 && hold < 3) begin
        r = 1'b0;
        hold++;
      end else r = 1'b1;
      bus.rd_ready = r;
      // Requests while not ready must be dropped; inject some to prove it.
      if ((m == RD_BURST && popped < n - 1) || (m != RD_BURST && !r)) begin
        bus.rd_req  = 1'($urandom_range(0, 1));
        bus.rd_mode = RD_PAIR;
        bus.rd_addr = 5'($urandom);
      end else bus.rd_req = 1'b0;
      #1;
      if (rmode == 0) begin
        chk("valid_timing", bus.rd_valid, (m == RD_BURST) ? (it >= 1) : 1'b1);
        chk("busy_timing", bus.busy, (m == RD_BURST) && (it < n));
        chk("req_rdy_timing", bus.rd_req_rdy, !((m == RD_BURST) && (it < n)));
      end
      if (m == RD_BURST && popped < n - 1) begin
        chk("busy_in_burst", bus.busy, 1'b1);
        chk("req_rdy_in_burst", bus.rd_req_rdy, 1'b0);
      end
      if (bus.rd_valid === 1'b1) begin
        chk("rd_data1", bus.rd_data1, exp_q[0].d1);
        chk("rd_data2", bus.rd_data2, exp_q[0].d2);
        chk("rd_last", bus.rd_last, exp_q[0].last);
        if (r) begin
          void'(exp_q.pop_front());
          popped++;
        end
      end
      tick();
      bus.rd_req = 1'b0;
      it++;
    end
    bus.rd_ready = 1'b1;
    chk("beats_delivered", 64'(exp_q.size()), 64'd0);
    if (rmode == 0) begin
      exp_it = (n == 0) ? 0 : ((m == RD_BURST) ? n + 1 : n);
      chk("cycle_count", 64'(it), 64'(exp_it));
    end
    #1;
    chk("valid_after", bus.rd_valid, 1'b0);
    chk("busy_after", bus.busy, 1'b0);
  endtask

  initial begin
    logic [63:0] merged;
    int          popped;
    int          guard;

    bus.rd_req    = 1'b0;
    bus.rd_mode   = RD_PAIR;
    bus.rd_addr   = '0;
    bus.rd_stride = '0;
    bus.rd_len    = '0;
    bus.rd_ready  = 1'b1;
    bus.wr_en     = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    bus.wr_be     = '0;

    #2 rst = 1'b0;
    #10;
    chk("rst_valid", bus.rd_valid, 1'b0);
    chk("rst_last", bus.rd_last, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_data1", bus.rd_data1, 64'h0);
    chk("rst_data2", bus.rd_data2, 64'h0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    for (int i = 0; i < DEPTH; i++) wr(5'(i), {$urandom, $urandom}, 8'hFF);

    // 1: basic PAIR
    wr(5'd5, 64'hAAAA_AAAA_AAAA_AAAA, 8'hFF);
    wr(5'd6, 64'hBBBB_BBBB_BBBB_BBBB, 8'hFF);
    run_req(RD_PAIR, 5'd5, 5'd0, 0, 0);

    // 2: wrap at top of array; SINGLE zeroes data2
    run_req(RD_PAIR, 5'd31, 5'd0, 0, 0);
    run_req(RD_SINGLE, 5'd31, 5'd0, 0, 0);

    // 3: strided burst with wrap (30, 1, 4, 7)
    run_req(RD_BURST, 5'd30, 5'd3, 4, 0);

    // 4: backpressure on beat 2
    run_req(RD_BURST, 5'd12, 5'd7, 4, 2);

    // reserved mode and zero-length burst: accepted, no beat
    run_req(RD_RSVD, 5'd4, 5'd1, 3, 0);
    run_req(RD_BURST, 5'd4, 5'd1, 0, 0);

    // 5: same-cycle partial write and PAIR read of the same word
    wr(5'd9, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    bus.wr_en   = 1'b1;
    bus.wr_addr = 5'd9;
    bus.wr_data = 64'h1111_1111_1111_1111;
    bus.wr_be   = 8'h0F;
    bus.rd_req  = 1'b1;
    bus.rd_mode = RD_PAIR;
    bus.rd_addr = 5'd9;
    tick();
    bus.wr_en  = 1'b0;
    bus.wr_be  = '0;
    bus.rd_req = 1'b0;
    merged = 64'hFFFF_FFFF_1111_1111;
`ifdef NLP_MEM_BYPASS_EN
    chk("rw_same_data1", bus.rd_data1, merged);
`else
    chk("rw_same_data1", bus.rd_data1, 64'hFFFF_FFFF_FFFF_FFFF);
`endif
    chk("rw_same_data2", bus.rd_data2, model[10]);
    chk("rw_same_valid", bus.rd_valid, 1'b1);
    model[9] = merged;
    tick();
    run_req(RD_PAIR, 5'd9, 5'd0, 0, 0);
    run_req(RD_PAIR, 5'd8, 5'd0, 0, 0);

    // byte-enable zero is a no-op
    wr(5'd9, {$urandom, $urandom}, 8'h00);
    run_req(RD_PAIR, 5'd9, 5'd0, 0, 0);

    // 6: async reset in the middle of a burst
    expect_beats(RD_BURST, 5'd3, 5'd5, 6);
    bus.rd_req    = 1'b1;
    bus.rd_mode   = RD_BURST;
    bus.rd_addr   = 5'd3;
    bus.rd_stride = 5'd5;
    bus.rd_len    = 8'd6;
    bus.rd_ready  = 1'b1;
    tick();
    bus.rd_req = 1'b0;
    popped = 0;
    guard  = 0;
    while (popped < 2 && guard < 20) begin
      if (bus.rd_valid === 1'b1) begin
        chk("pre_rst_data1", bus.rd_data1, exp_q[0].d1);
        void'(exp_q.pop_front());
        popped++;
      end
      tick();
      guard++;
    end
    chk("pre_rst_beats", 64'(popped), 64'd2);
    chk("pre_rst_busy", bus.busy, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("arst_valid", bus.rd_valid, 1'b0);
    chk("arst_busy", bus.busy, 1'b0);
    chk("arst_last", bus.rd_last, 1'b0);
    chk("arst_data1", bus.rd_data1, 64'h0);
    chk("arst_data2", bus.rd_data2, 64'h0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    run_req(RD_PAIR, 5'd3, 5'd0, 0, 0);
    run_req(RD_PAIR, 5'd5, 5'd0, 0, 0);

    // randomized traffic
    for (int t = 0; t < 60; t++) begin
      for (int w = 0; w < int'($urandom_range(0, 2)); w++)
        wr(5'($urandom), {$urandom, $urandom}, 8'($urandom));
      run_req(rd_mode_e'($urandom_range(0, 3)), 5'($urandom), 5'($urandom),
              int'($urandom_range(0, 6)), int'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
